cpu_run_ctrl: RTL

Run/step/breakpoint controller that sits directly upstream of the multi-cycle CPU.
- Produces the CPU clock-enable (cpu_en), so the CPU advances only when permitted.
- Always halts the CPU on an instruction boundary, i.e. with the CPU in its IF state.
- Counts executed cycles and retired instructions for the board debug display.
- Inputs are the board switch/button and the CPU's isIF and pc_out outputs.

---
 rtl/cpu_run_ctrl_pkg.sv | 15 +
 rtl/cpu_run_ctrl_in_debounce.sv | 51 +++++
 rtl/cpu_run_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/step/breakpoint controller:
// FSM state encoding and default parameter values.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP0 = 2'd2,
    STEP1 = 2'd3
  } run_state_t;

  localparam int DEF_DB_CYCLES = 1000000;
  localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/cpu_run_ctrl_in_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
// Provides the accepted level and a one-cycle pulse on its rising edge.
module in_debounce
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          level_q;
  logic          level_d1;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      level_q  <= 1'b0;
      level_d1 <= 1'b0;
      cnt      <= '0;
    end else begin
      sync0    <= din;
      sync1    <= sync0;
      level_d1 <= level_q;
      if (sync1 == level_q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level_q <= sync1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign pulse = level_q & ~level_d1;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller producing the CPU clock enable; it only
// ever stops the CPU in its IF state and counts cycles and instructions.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic             is_if,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  run_state_t state;
  run_state_t state_next;
  logic       skip_bp;
  logic       skip_next;
  logic       bp_hit_next;
  logic       bp_match;

  logic run_level;
  logic run_pulse;
  logic step_level;
  logic step_pulse;
  logic unused_ok;

  in_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
    .clk   (clk),
    .rst   (rst),
    .din   (run_sw),
    .level (run_level),
    .pulse (run_pulse)
  );

  in_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .din   (step_btn),
    .level (step_level),
    .pulse (step_pulse)
  );

  assign unused_ok = run_pulse ^ step_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HALT;
      skip_bp <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      state   <= state_next;
      skip_bp <= skip_next;
      bp_hit  <= bp_hit_next;
    end
  end

  // skip_bp suppresses the breakpoint we are resuming from until the CPU
  // has actually fetched that instruction once.
  assign bp_match = bp_en & (pc == bp_addr) & ~skip_bp;

  always_comb begin
    state_next  = state;
    skip_next   = skip_bp;
    bp_hit_next = bp_hit;
    cpu_en      = 1'b0;
    case (state)
      HALT: begin
        if (run_level) begin
          state_next  = RUN;
          skip_next   = 1'b1;
          bp_hit_next = 1'b0;
        end else if (step_pulse) begin
          state_next  = STEP0;
          bp_hit_next = 1'b0;
        end
      end
      RUN: begin
        if (is_if & (~run_level | bp_match)) begin
          state_next = HALT;
          if (bp_match) bp_hit_next = 1'b1;
        end else begin
          cpu_en = 1'b1;
          if (is_if) skip_next = 1'b0;
        end
      end
      STEP0: begin
        cpu_en     = 1'b1;
        state_next = STEP1;
      end
      STEP1: begin
        if (is_if) state_next = HALT;
        else       cpu_en     = 1'b1;
      end
      default: state_next = HALT;
    endcase
  end

  assign halted = (state == HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (is_if) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule
